// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_pkg
// Brief    : Shared constants, clear-FSM state type and byte-merge helper
//            for the parametrised single-port RAM.
// Revision : 1.0 - initial release
// ============================================================================
package ram_pkg;

    localparam int RD_ASYNC = 0;
    localparam int RD_SYNC  = 1;
    localparam int RDW_OLD  = 0;
    localparam int RDW_NEW  = 1;

    // Widest word the merge helper handles; callers cast to and from their width.
    localparam int MAX_DATA_W = 256;
    localparam int MAX_NB     = MAX_DATA_W / 8;

    typedef logic [0:0] clr_state_t;
    localparam clr_state_t CLEAR = 1'b0;
    localparam clr_state_t READY = 1'b1;

    function automatic logic [MAX_DATA_W-1:0] merge_bytes(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_NB-1:0]     be
    );
        logic [MAX_DATA_W-1:0] w_word;
        w_word = old_word;
        for (int k = 0; k < MAX_NB; k++) begin
            if (be[k]) w_word[8*k +: 8] = new_word[8*k +: 8];
        end
        return w_word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_sp_param_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_sp_param_if
// Brief    : User access bus of the single-port RAM (address/data/strobes).
// Revision : 1.0 - initial release
// ============================================================================
interface ram_sp_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    localparam int NB = DATA_W / 8;

    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic              write_en;
    logic [NB-1:0]     byte_en;
    logic              read_en;
    logic              clear_req;
    logic              busy;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;

    modport master (
        output address, data_in, write_en, byte_en, read_en, clear_req,
        input  busy, data_out, data_valid
    );

    modport slave (
        input  address, data_in, write_en, byte_en, read_en, clear_req,
        output busy, data_out, data_valid
    );
endinterface
`default_nettype wire

// File: rtl/ram_clear_seq.sv
`default_nettype none
// ============================================================================
// Module   : ram_clear_seq
// Brief    : Clear sweep FSM; walks every address once after reset or request.
// Revision : 1.0 - initial release
// ============================================================================
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              clear_req,
    output logic                   busy,
    output logic                   clr_we,
    output logic [ADDR_W-1:0]      clr_addr
);
    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);

    clr_state_t        r_state;
    logic [ADDR_W-1:0] r_addr;

    // A request seen while sweeping is ignored, so an active sweep never restarts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= CLEAR;
            r_addr  <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (r_addr == C_LAST) begin
                        r_state <= READY;
                        r_addr  <= '0;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                READY: begin
                    if (clear_req) begin
                        r_state <= CLEAR;
                        r_addr  <= '0;
                    end
                end
                default: begin
                    r_state <= CLEAR;
                    r_addr  <= '0;
                end
            endcase
        end
    end

    assign busy     = (r_state == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = r_addr;

endmodule
`default_nettype wire

// File: rtl/ram_sp_param.sv
`default_nettype none
// ============================================================================
// Module   : ram_sp_param
// Brief    : Single-port RAM, byte enables, async/sync read, built-in clear.
// Revision : 1.0 - initial release
// ============================================================================
module ram_sp_param
    import ram_pkg::*;
#(
    parameter int                 DATA_W    = 8,
    parameter int                 DEPTH     = 16,
    parameter int                 READ_MODE = RD_ASYNC,
    parameter int                 RDW_MODE  = RDW_OLD,
    parameter logic [DATA_W-1:0]  INIT_VAL  = '0
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    ram_sp_param_if.slave      bus
);
    localparam int                ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                NB      = DATA_W / 8;
    localparam logic [ADDR_W:0]   C_DEPTH = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_in_range;
    logic              w_user_we;
    logic              w_rd_acc;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_merged;

    ram_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_req (bus.clear_req),
        .busy      (w_busy),
        .clr_we    (w_clr_we),
        .clr_addr  (w_clr_addr)
    );

    assign w_in_range = ({1'b0, bus.address} < C_DEPTH);
    assign w_user_we  = bus.write_en & ~w_busy & w_in_range;
    assign w_rd_acc   = bus.read_en & ~w_busy;
    assign w_rd_word  = w_in_range ? r_mem[bus.address] : '0;
    assign w_merged   = DATA_W'(merge_bytes(MAX_DATA_W'(w_rd_word),
                                            MAX_DATA_W'(bus.data_in),
                                            MAX_NB'(bus.byte_en)));
    assign bus.busy   = w_busy;

    // The sweep owns the array while busy; user writes are already gated off then.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= INIT_VAL;
        end else if (w_user_we) begin
            r_mem[bus.address] <= w_merged;
        end
    end

    if (READ_MODE == RD_SYNC) begin : g_sync
        logic [DATA_W-1:0] r_data_out;
        logic              r_data_valid;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_data_out   <= '0;
                r_data_valid <= 1'b0;
            end else begin
                r_data_valid <= w_rd_acc;
                if (w_rd_acc) begin
                    r_data_out <= (RDW_MODE == RDW_NEW && w_user_we) ? w_merged : w_rd_word;
                end
            end
        end

        assign bus.data_out   = r_data_out;
        assign bus.data_valid = r_data_valid;
    end else begin : g_async
        assign bus.data_out   = w_rd_word;
        assign bus.data_valid = w_rd_acc;
    end

    if (NB * 8 != DATA_W) begin : g_width_chk
        $error("ram_sp_param: DATA_W must be a multiple of 8");
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_sp_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_sp_param
// Brief    : Directed self-checking bench over five RAM configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_sp_param;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // b0: 8b async D16 | b1: 32b async D16 | b2/b3: 8b sync old/new | b4: 8b async D12
    ram_sp_param_if #(.DATA_W(8),  .ADDR_W(4)) b0 ();
    ram_sp_param_if #(.DATA_W(32), .ADDR_W(4)) b1 ();
    ram_sp_param_if #(.DATA_W(8),  .ADDR_W(4)) b2 ();
    ram_sp_param_if #(.DATA_W(8),  .ADDR_W(4)) b3 ();
    ram_sp_param_if #(.DATA_W(8),  .ADDR_W(4)) b4 ();

    ram_sp_param #(.DATA_W(8),  .DEPTH(16), .READ_MODE(0)) u0 (.clk(clk), .reset_n(reset_n), .bus(b0));
    ram_sp_param #(.DATA_W(32), .DEPTH(16), .READ_MODE(0)) u1 (.clk(clk), .reset_n(reset_n), .bus(b1));
    ram_sp_param #(.DATA_W(8),  .DEPTH(16), .READ_MODE(1), .RDW_MODE(0)) u2 (.clk(clk), .reset_n(reset_n), .bus(b2));
    ram_sp_param #(.DATA_W(8),  .DEPTH(16), .READ_MODE(1), .RDW_MODE(1)) u3 (.clk(clk), .reset_n(reset_n), .bus(b3));
    ram_sp_param #(.DATA_W(8),  .DEPTH(12), .READ_MODE(0)) u4 (.clk(clk), .reset_n(reset_n), .bus(b4));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int c0, c1, c4, cc, vbad;
        b0.address = '0; b0.data_in = '0; b0.write_en = 0; b0.byte_en = 1'b1; b0.read_en = 0; b0.clear_req = 0;
        b1.address = '0; b1.data_in = '0; b1.write_en = 0; b1.byte_en = 4'hF; b1.read_en = 0; b1.clear_req = 0;
        b2.address = '0; b2.data_in = '0; b2.write_en = 0; b2.byte_en = 1'b1; b2.read_en = 0; b2.clear_req = 0;
        b3.address = '0; b3.data_in = '0; b3.write_en = 0; b3.byte_en = 1'b1; b3.read_en = 0; b3.clear_req = 0;
        b4.address = '0; b4.data_in = '0; b4.write_en = 0; b4.byte_en = 1'b1; b4.read_en = 0; b4.clear_req = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(b0.busy), 32'd1);
        check("rst_sync_valid", 32'(b2.data_valid), 32'd0);
        check("rst_sync_dout", 32'(b2.data_out), 32'd0);

        // Release, then abort the sweep with reset at sweep cycle 5
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1 check("midsweep_rst_busy", 32'(b4.busy), 32'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        c0 = 0; c1 = 0; c4 = 0;
        for (int i = 0; i < 30; i++) begin
            if (b0.busy) c0++;
            if (b1.busy) c1++;
            if (b4.busy) c4++;
            @(negedge clk);
        end
        check("sweep_len_d16", 32'(c0), 32'd16);
        check("sweep_len_d16_w32", 32'(c1), 32'd16);
        check("sweep_len_d12", 32'(c4), 32'd12);

        // All locations hold INIT_VAL after the power-on sweep
        b0.read_en = 1'b1;
        for (int a = 0; a < 16; a++) begin
            b0.address = 4'(a);
            @(negedge clk);
            check("init_read", 32'(b0.data_out), 32'h00);
        end
        check("async_valid", 32'(b0.data_valid), 32'd1);
        b0.read_en = 1'b0;
        #1 check("async_valid_low", 32'(b0.data_valid), 32'd0);

        // 32-bit byte-lane merge
        @(negedge clk);
        b1.address = 4'd3; b1.data_in = 32'hAABBCCDD; b1.byte_en = 4'hF; b1.write_en = 1'b1;
        @(negedge clk);
        b1.data_in = 32'h11223344; b1.byte_en = 4'b0101;
        @(negedge clk);
        b1.write_en = 1'b0; b1.read_en = 1'b1;
        #1 check("byte_merge", b1.data_out, 32'hAA22CC44);
        b1.data_in = 32'hFFFFFFFF; b1.byte_en = 4'h0; b1.write_en = 1'b1;
        @(negedge clk);
        b1.write_en = 1'b0;
        #1 check("be_zero_nochange", b1.data_out, 32'hAA22CC44);
        b1.read_en = 1'b0;

        // Sync read latency and one-cycle valid pulse
        @(negedge clk);
        b2.address = 4'd5; b2.data_in = 8'h5A; b2.write_en = 1'b1;
        b3.address = 4'd5; b3.data_in = 8'h5A; b3.write_en = 1'b1;
        @(negedge clk);
        b2.write_en = 1'b0; b2.read_en = 1'b1;
        b3.write_en = 1'b0; b3.read_en = 1'b1;
        #1 check("sync_valid_before_edge", 32'(b2.data_valid), 32'd0);
        @(negedge clk);
        b2.read_en = 1'b0; b3.read_en = 1'b0;
        check("sync_dout_n1", 32'(b2.data_out), 32'h5A);
        check("sync_valid_n1", 32'(b2.data_valid), 32'd1);
        check("sync_new_dout_n1", 32'(b3.data_out), 32'h5A);
        @(negedge clk);
        check("sync_valid_n2", 32'(b2.data_valid), 32'd0);
        check("sync_dout_hold", 32'(b2.data_out), 32'h5A);

        // Read-during-write on the same address
        b2.address = 4'd2; b2.data_in = 8'h12; b2.write_en = 1'b1;
        b3.address = 4'd2; b3.data_in = 8'h12; b3.write_en = 1'b1;
        @(negedge clk);
        b2.data_in = 8'h77; b2.read_en = 1'b1;
        b3.data_in = 8'h77; b3.read_en = 1'b1;
        @(negedge clk);
        b2.write_en = 1'b0; b2.read_en = 1'b0;
        b3.write_en = 1'b0; b3.read_en = 1'b0;
        check("rdw_old", 32'(b2.data_out), 32'h12);
        check("rdw_new", 32'(b3.data_out), 32'h77);
        b2.read_en = 1'b1;
        @(negedge clk);
        b2.read_en = 1'b0;
        check("rdw_old_after", 32'(b2.data_out), 32'h77);

        // Out-of-range access on DEPTH=12
        b4.address = 4'd13; b4.data_in = 8'hAB; b4.write_en = 1'b1;
        @(negedge clk);
        b4.write_en = 1'b0; b4.read_en = 1'b1;
        #1 check("oor_read_zero", 32'(b4.data_out), 32'h00);
        check("oor_read_valid", 32'(b4.data_valid), 32'd1);
        b4.address = 4'd5;
        #1 check("oor_no_alias5", 32'(b4.data_out), 32'h00);
        b4.address = 4'd1;
        #1 check("oor_no_alias1", 32'(b4.data_out), 32'h00);
        b4.read_en = 1'b0; b4.address = 4'd11; b4.data_in = 8'h3C; b4.write_en = 1'b1;
        @(negedge clk);
        b4.write_en = 1'b0; b4.read_en = 1'b1;
        #1 check("last_addr_rw", 32'(b4.data_out), 32'h3C);
        b4.read_en = 1'b0;

        // Fill, then clear_req together with a write, then sweep
        @(negedge clk);
        for (int a = 0; a < 16; a++) begin
            b0.address = 4'(a); b0.data_in = 8'(a) ^ 8'hA5; b0.write_en = 1'b1;
            @(negedge clk);
        end
        b0.write_en = 1'b0; b0.read_en = 1'b1; b0.address = 4'd7;
        #1 check("fill_readback", 32'(b0.data_out), 32'hA2);
        b0.address = 4'd0; b0.data_in = 8'hEE; b0.write_en = 1'b1; b0.clear_req = 1'b1;
        @(negedge clk);
        b0.clear_req = 1'b0; b0.address = 4'd4; b0.data_in = 8'h99;
        #1 check("clear_busy", 32'(b0.busy), 32'd1);
        cc = 0; vbad = 0;
        for (int i = 0; i < 40; i++) begin
            if (b0.busy) cc++;
            if (b0.busy && b0.data_valid) vbad++;
            b0.clear_req = (i == 3);
            b0.write_en  = b0.busy;
            @(negedge clk);
        end
        b0.write_en = 1'b0; b0.clear_req = 1'b0;
        check("clear_sweep_len", 32'(cc), 32'd16);
        check("valid_while_busy", 32'(vbad), 32'd0);
        for (int a = 0; a < 16; a++) begin
            b0.address = 4'(a);
            @(negedge clk);
            check("post_clear_read", 32'(b0.data_out), 32'h00);
        end
        b0.read_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
